// File: rtl/latency_probe_rx.sv
// Latency-probe receiver: forwards an AXI-stream through one register slice and, on the
// first beat of each packet, measures rx-time minus tx-time and checks the CHDR seqnum.
module latency_probe_rx #(
    parameter int unsigned SUM_W = 48,
    parameter int unsigned ERR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_stats,
    input  logic               clear_tx_seqnum,
    input  logic [63:0]        timer,
    input  logic [31:0]        i_tdata,
    input  logic               i_tlast,
    input  logic               i_tvalid,
    input  logic [127:0]       i_tuser,
    output logic               i_tready,
    output logic [31:0]        o_tdata,
    output logic               o_tlast,
    output logic               o_tvalid,
    output logic [127:0]       o_tuser,
    input  logic               o_tready,
    output logic [31:0]        lat_last,
    output logic [31:0]        lat_min,
    output logic [31:0]        lat_max,
    output logic [SUM_W-1:0]   lat_sum,
    output logic [31:0]        pkt_count,
    output logic [ERR_W-1:0]   seq_err_count,
    output logic               result_stb
);

    typedef enum logic [1:0] {StSync, StSop, StBody} state_e;

    state_e             state_q, state_d;
    logic [31:0]        o_tdata_q, o_tdata_d;
    logic               o_tlast_q, o_tlast_d;
    logic               o_tvalid_q, o_tvalid_d;
    logic [127:0]       o_tuser_q, o_tuser_d;
    logic [31:0]        lat_last_q, lat_last_d;
    logic [31:0]        lat_min_q, lat_min_d;
    logic [31:0]        lat_max_q, lat_max_d;
    logic [SUM_W-1:0]   lat_sum_q, lat_sum_d;
    logic [31:0]        pkt_count_q, pkt_count_d;
    logic [ERR_W-1:0]   seq_err_q, seq_err_d;
    logic [11:0]        exp_seq_q, exp_seq_d;
    logic               result_stb_q, result_stb_d;

    logic               hs;
    logic               meas;
    logic [31:0]        lat;
    logic [11:0]        seq;
    logic [11:0]        exp_cmp;
    logic [SUM_W:0]     sum_ext;
    logic [31:0]        base_min, base_max;
    logic [SUM_W-1:0]   base_sum;
    logic [31:0]        base_count;
    logic [ERR_W-1:0]   base_err;

    // Only the low timer word takes part in the modulo-2^32 latency.
    logic unused_timer_hi;
    assign unused_timer_hi = ^timer[63:32];

    assign i_tready = ~o_tvalid_q | o_tready;
    assign hs       = i_tvalid & i_tready;
    assign meas     = hs & (state_q == StSop);
    assign lat      = timer[31:0] - i_tuser[31:0];
    assign seq      = i_tuser[123:112];
    assign exp_cmp  = clear_tx_seqnum ? 12'd0 : exp_seq_q;

    // Register slice next-state: load on handshake, drain when downstream takes the beat.
    always_comb begin
        o_tdata_d  = o_tdata_q;
        o_tlast_d  = o_tlast_q;
        o_tuser_d  = o_tuser_q;
        o_tvalid_d = o_tvalid_q;
        if (hs) begin
            o_tdata_d  = i_tdata;
            o_tlast_d  = i_tlast;
            o_tuser_d  = i_tuser;
            o_tvalid_d = 1'b1;
        end else if (o_tready) begin
            o_tvalid_d = 1'b0;
        end
    end

    // Packet framing FSM: SYNC waits for a tlast so a cut packet is never measured.
    always_comb begin
        state_d = state_q;
        if (hs) begin
            unique case (state_q)
                StSync:  if (i_tlast) state_d = StSop;
                StSop:   state_d = i_tlast ? StSop : StBody;
                StBody:  if (i_tlast) state_d = StSop;
                default: state_d = StSync;
            endcase
        end
    end

    // Statistics next-state: clear first, then fold in a coinciding measurement.
    always_comb begin
        base_min   = clear_stats ? 32'hFFFF_FFFF : lat_min_q;
        base_max   = clear_stats ? 32'd0 : lat_max_q;
        base_sum   = clear_stats ? '0 : lat_sum_q;
        base_count = clear_stats ? 32'd0 : pkt_count_q;
        base_err   = clear_stats ? '0 : seq_err_q;
        sum_ext    = {1'b0, base_sum} + (SUM_W + 1)'(lat);

        lat_last_d   = clear_stats ? 32'd0 : lat_last_q;
        lat_min_d    = base_min;
        lat_max_d    = base_max;
        lat_sum_d    = base_sum;
        pkt_count_d  = base_count;
        seq_err_d    = base_err;
        exp_seq_d    = exp_cmp;
        result_stb_d = meas;

        if (meas) begin
            lat_last_d  = lat;
            lat_min_d   = (lat < base_min) ? lat : base_min;
            lat_max_d   = (lat > base_max) ? lat : base_max;
            lat_sum_d   = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
            pkt_count_d = base_count + 32'd1;
            if ((seq != exp_cmp) && (base_err != {ERR_W{1'b1}})) begin
                seq_err_d = base_err + ERR_W'(1);
            end
            exp_seq_d = seq + 12'd1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StSync;
            o_tdata_q    <= '0;
            o_tlast_q    <= 1'b0;
            o_tvalid_q   <= 1'b0;
            o_tuser_q    <= '0;
            lat_last_q   <= '0;
            lat_min_q    <= 32'hFFFF_FFFF;
            lat_max_q    <= '0;
            lat_sum_q    <= '0;
            pkt_count_q  <= '0;
            seq_err_q    <= '0;
            exp_seq_q    <= '0;
            result_stb_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_tdata_q    <= o_tdata_d;
            o_tlast_q    <= o_tlast_d;
            o_tvalid_q   <= o_tvalid_d;
            o_tuser_q    <= o_tuser_d;
            lat_last_q   <= lat_last_d;
            lat_min_q    <= lat_min_d;
            lat_max_q    <= lat_max_d;
            lat_sum_q    <= lat_sum_d;
            pkt_count_q  <= pkt_count_d;
            seq_err_q    <= seq_err_d;
            exp_seq_q    <= exp_seq_d;
            result_stb_q <= result_stb_d;
        end
    end

    assign o_tdata       = o_tdata_q;
    assign o_tlast       = o_tlast_q;
    assign o_tvalid      = o_tvalid_q;
    assign o_tuser       = o_tuser_q;
    assign lat_last      = lat_last_q;
    assign lat_min       = lat_min_q;
    assign lat_max       = lat_max_q;
    assign lat_sum       = lat_sum_q;
    assign pkt_count     = pkt_count_q;
    assign seq_err_count = seq_err_q;
    assign result_stb    = result_stb_q;

endmodule

// File: tb/tb_latency_probe_rx.sv
// Directed bench for latency_probe_rx: forwarding scoreboard plus hand-computed statistics.
module tb_latency_probe_rx;

    logic         clk;
    logic         reset;
    logic         clear_stats;
    logic         clear_tx_seqnum;
    logic [63:0]  timer;
    logic [63:0]  timer_cnt = 64'd0;
    logic [63:0]  timer_off = 64'h100;
    logic [31:0]  i_tdata;
    logic         i_tlast;
    logic         i_tvalid;
    logic [127:0] i_tuser;
    logic         i_tready;
    logic [31:0]  o_tdata;
    logic         o_tlast;
    logic         o_tvalid;
    logic [127:0] o_tuser;
    logic         o_tready;
    logic [31:0]  lat_last, lat_min, lat_max, pkt_count;
    logic [47:0]  lat_sum;
    logic [15:0]  seq_err_count;
    logic         result_stb;

    typedef struct packed {
        logic         last;
        logic [31:0]  data;
        logic [127:0] user;
    } beat_t;

    beat_t sb[$];
    int    n_total = 0;
    int    n_bad   = 0;
    int    stb_cnt = 0;
    int    stb_snap;

    latency_probe_rx #(.SUM_W(48), .ERR_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .clear_stats     (clear_stats),
        .clear_tx_seqnum (clear_tx_seqnum),
        .timer           (timer),
        .i_tdata         (i_tdata),
        .i_tlast         (i_tlast),
        .i_tvalid        (i_tvalid),
        .i_tuser         (i_tuser),
        .i_tready        (i_tready),
        .o_tdata         (o_tdata),
        .o_tlast         (o_tlast),
        .o_tvalid        (o_tvalid),
        .o_tuser         (o_tuser),
        .o_tready        (o_tready),
        .lat_last        (lat_last),
        .lat_min         (lat_min),
        .lat_max         (lat_max),
        .lat_sum         (lat_sum),
        .pkt_count       (pkt_count),
        .seq_err_count   (seq_err_count),
        .result_stb      (result_stb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) timer_cnt <= timer_cnt + 64'd1;
    assign timer = timer_cnt + timer_off;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: sample mid-cycle the transfers that complete on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_tvalid && o_tready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_beat", {63'd0, o_tvalid}, 64'd0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("sb_data", {31'd0, o_tlast, o_tdata}, {31'd0, e.last, e.data});
                    check("sb_user_hi", o_tuser[127:64], e.user[127:64]);
                    check("sb_user_lo", o_tuser[63:0], e.user[63:0]);
                end
            end
            if (i_tvalid && i_tready) sb.push_back('{last: i_tlast, data: i_tdata, user: i_tuser});
            if (result_stb) stb_cnt++;
        end
    end

    // The beat held in the output slice is discarded by reset.
    always @(posedge reset) sb.delete();

    function automatic logic [127:0] mk_user(input logic [11:0] seq, input logic [31:0] tx);
        logic [63:0] hdr;
        hdr = {4'h0, seq, 48'h0000_CAFE_0000};
        return {hdr, 32'h0, tx};
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic l, input logic [127:0] u);
        int n;
        n = 0;
        i_tdata  = d;
        i_tlast  = l;
        i_tuser  = u;
        i_tvalid = 1'b1;
        #1;
        while (!i_tready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("hs_timeout", {63'd0, i_tready}, 64'd1);
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input logic [11:0] seq, input logic [31:0] tx,
                            input logic [31:0] base);
        for (int b = 0; b < nb; b++) begin
            send_beat(base + 32'(b), (b == nb - 1),
                      mk_user(seq, (b == 0) ? tx : (32'hDEAD_0000 | 32'(b))));
        end
    endtask

    task automatic check_stats(input string t, input logic [31:0] last, input logic [31:0] mn,
                               input logic [31:0] mx, input logic [47:0] sum,
                               input logic [31:0] cnt, input logic [15:0] err);
        check({t, "_last"}, 64'(lat_last), 64'(last));
        check({t, "_min"}, 64'(lat_min), 64'(mn));
        check({t, "_max"}, 64'(lat_max), 64'(mx));
        check({t, "_sum"}, 64'(lat_sum), 64'(sum));
        check({t, "_count"}, 64'(pkt_count), 64'(cnt));
        check({t, "_seqerr"}, 64'(seq_err_count), 64'(err));
    endtask

    initial begin
        reset = 1'b1;
        clear_stats = 1'b0;
        clear_tx_seqnum = 1'b0;
        i_tdata = '0;
        i_tlast = 1'b0;
        i_tvalid = 1'b0;
        i_tuser = '0;
        o_tready = 1'b1;
        #3;
        check("rst_o_tvalid", {63'd0, o_tvalid}, 64'd0);
        check("rst_o_tdata", 64'(o_tdata), 64'd0);
        check("rst_stb", {63'd0, result_stb}, 64'd0);
        check_stats("rst", 32'd0, 32'hFFFF_FFFF, 32'd0, 48'd0, 32'd0, 16'd0);
        #19;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // T1: first packet after reset only resyncs; second is measured with lat 7.
        send_pkt(1, 12'd9, timer[31:0] - 32'd50, 32'h1000_0000);
        check("t1_sync_count", 64'(pkt_count), 64'd0);
        send_pkt(4, 12'd0, timer[31:0] - 32'd7, 32'h1100_0000);
        check_stats("t1", 32'd7, 32'd7, 32'd7, 48'd7, 32'd1, 16'd0);
        check("t1_stb", 64'(stb_cnt), 64'd1);

        // T2: lat 12, downstream stalls for 5 cycles after the first beat.
        send_beat(32'hA000_0000, 1'b0, mk_user(12'd1, timer[31:0] - 32'd12));
        o_tready = 1'b0;
        i_tdata  = 32'hA000_0001;
        i_tlast  = 1'b0;
        i_tuser  = mk_user(12'd1, 32'hDEAD_0001);
        i_tvalid = 1'b1;
        #1;
        check("t2_ready_low", {63'd0, i_tready}, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t2_hold_valid", {63'd0, o_tvalid}, 64'd1);
        check("t2_hold_data", 64'(o_tdata), 64'hA000_0000);
        check("t2_ready_still_low", {63'd0, i_tready}, 64'd0);
        o_tready = 1'b1;
        send_beat(32'hA000_0001, 1'b0, mk_user(12'd1, 32'hDEAD_0001));
        send_beat(32'hA000_0002, 1'b0, mk_user(12'd1, 32'hDEAD_0002));
        send_beat(32'hA000_0003, 1'b1, mk_user(12'd1, 32'hDEAD_0003));
        check_stats("t2", 32'd12, 32'd7, 32'd12, 48'd19, 32'd2, 16'd0);

        // T3: timer wraps between tx and rx.
        timer_off = 64'd3 - timer_cnt;
        send_pkt(1, 12'd2, 32'hFFFF_FFFE, 32'h3000_0000);
        check_stats("t3", 32'd5, 32'd5, 32'd12, 48'd24, 32'd3, 16'd0);

        // T4: seq jump 2 -> 5 is one error, then resynced.
        send_pkt(2, 12'd5, timer[31:0] - 32'd4, 32'h4000_0000);
        check("t4_err_after_jump", 64'(seq_err_count), 64'd1);
        send_pkt(1, 12'd6, timer[31:0] - 32'd30, 32'h4100_0000);
        check_stats("t4", 32'd30, 32'd4, 32'd30, 48'd58, 32'd5, 16'd1);
        clear_tx_seqnum = 1'b1;
        @(posedge clk);
        #1;
        clear_tx_seqnum = 1'b0;
        send_pkt(3, 12'd0, timer[31:0] - 32'd8, 32'h4200_0000);
        check_stats("t4_clrseq", 32'd8, 32'd4, 32'd30, 48'd66, 32'd6, 16'd1);

        // T5: clear_stats coinciding with an SOP leaves that packet as the only entry.
        send_pkt(1, 12'd1, timer[31:0] - 32'd10, 32'h5000_0000);
        send_pkt(2, 12'd2, timer[31:0] - 32'd3, 32'h5100_0000);
        send_pkt(1, 12'd3, timer[31:0] - 32'd20, 32'h5200_0000);
        check_stats("t5_pre", 32'd20, 32'd3, 32'd30, 48'd99, 32'd9, 16'd1);
        clear_stats = 1'b1;
        send_beat(32'h5300_0000, 1'b1, mk_user(12'd4, timer[31:0] - 32'd9));
        clear_stats = 1'b0;
        check_stats("t5_clr", 32'd9, 32'd9, 32'd9, 48'd9, 32'd1, 16'd0);

        // T6: asynchronous reset in the middle of a packet.
        send_beat(32'h6000_0000, 1'b0, mk_user(12'd5, timer[31:0] - 32'd2));
        send_beat(32'h6000_0001, 1'b0, mk_user(12'd5, 32'hDEAD_0001));
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_o_tvalid", {63'd0, o_tvalid}, 64'd0);
        check("t6_rst_o_tdata", 64'(o_tdata), 64'd0);
        check("t6_rst_i_tready", {63'd0, i_tready}, 64'd1);
        check_stats("t6_rst", 32'd0, 32'hFFFF_FFFF, 32'd0, 48'd0, 32'd0, 16'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        stb_snap = stb_cnt;
        send_beat(32'h6000_0002, 1'b1, mk_user(12'd5, timer[31:0] - 32'd77));
        #2;
        check("t6_tail_count", 64'(pkt_count), 64'd0);
        check("t6_tail_nostb", 64'(stb_cnt), 64'(stb_snap));
        send_pkt(2, 12'd0, timer[31:0] - 32'd6, 32'h6100_0000);
        check_stats("t6_next", 32'd6, 32'd6, 32'd6, 48'd6, 32'd1, 16'd0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("o_tvalid_idle", {63'd0, o_tvalid}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
